// File: rtl/pu_stream_initiator_pkg.sv
// Shared types and helpers for the PU stream initiator: FSM state encoding,
// data-width derivation and a ceil-log2 used to size FIFO pointers.
package pu_stream_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int calc_data_width(input int op_width, input int num_pe);
    return op_width * num_pe;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pu_stream_initiator_if.sv
// Memory-side read/write port plus datapath input/result streams of the initiator.
// master = initiator side, slave = responder / datapath side.
interface pu_stream_initiator_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  pu_rd_req;
  logic                  pu_rd_ready;
  logic [DATA_WIDTH-1:0] pu_data_in;
  logic                  pu_wr_req;
  logic [DATA_WIDTH-1:0] pu_data_out;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ready;

  modport master (
    output pu_rd_req, pu_wr_req, pu_data_out, in_valid, in_data, res_ready,
    input  pu_rd_ready, pu_data_in, in_ready, res_valid, res_data
  );

  modport slave (
    input  pu_rd_req, pu_wr_req, pu_data_out, in_valid, in_data, res_ready,
    output pu_rd_ready, pu_data_in, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/pu_stream_initiator_sync_fifo.sv
// Synchronous FIFO with occupancy count; push-to-pop latency 1 cycle, head shown combinationally.
// No internal backpressure: the caller must never push when full.
module pu_sync_fifo
  import pu_stream_initiator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/pu_stream_initiator.sv
// PU-side initiator: issues word reads into an input FIFO for the datapath and turns results into writes.
// Read data lands 2 cycles after the issuing edge; write strobe follows result acceptance by 1 cycle.
module pu_stream_initiator
  import pu_stream_initiator_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 20
)(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_rd_words,
  input  logic [CNT_W-1:0]         cfg_wr_words,
  pu_stream_initiator_if.master    bus,
  output logic                     busy,
  output logic                     done
);
  localparam int DATA_WIDTH = calc_data_width(OP_WIDTH, NUM_PE);
  localparam int CW         = clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cfg_rd;
  logic [CNT_W-1:0] cfg_wr;
  logic [CNT_W-1:0] rd_issued;
  logic [CNT_W-1:0] wr_issued;
  logic             rd_pend;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW:0]      in_use;
  logic             rd_go;
  logic             wr_acc;
  logic             fifo_pop;

  pu_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (rd_pend),
    .push_dat (bus.pu_data_in),
    .pop      (fifo_pop),
    .pop_dat  (bus.in_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.in_valid = !fifo_empty;
  assign fifo_pop     = !fifo_empty && bus.in_ready;

  // Both the request on the wire and the word in the responder pipe hold a FIFO slot.
  assign in_use = {1'b0, fifo_count} + {{CW{1'b0}}, bus.pu_rd_req} + {{CW{1'b0}}, rd_pend};
  assign rd_go  = (state == ST_RUN) && (rd_issued < cfg_rd) && bus.pu_rd_ready &&
                  (in_use < (CW+1)'(FIFO_DEPTH));

  assign bus.res_ready = ((state == ST_RUN) || (state == ST_DRAIN)) && (wr_issued < cfg_wr);
  assign wr_acc        = bus.res_valid && bus.res_ready;
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cfg_rd          <= '0;
      cfg_wr          <= '0;
      rd_issued       <= '0;
      wr_issued       <= '0;
      rd_pend         <= 1'b0;
      bus.pu_rd_req   <= 1'b0;
      bus.pu_wr_req   <= 1'b0;
      bus.pu_data_out <= '0;
      done            <= 1'b0;
    end else begin
      done          <= 1'b0;
      bus.pu_rd_req <= rd_go;
      rd_pend       <= bus.pu_rd_req;
      bus.pu_wr_req <= wr_acc;
      if (rd_go) rd_issued <= rd_issued + CNT_W'(1);
      if (wr_acc) begin
        bus.pu_data_out <= bus.res_data;
        wr_issued       <= wr_issued + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_rd    <= cfg_rd_words;
            cfg_wr    <= cfg_wr_words;
            rd_issued <= '0;
            wr_issued <= '0;
            state     <= ((cfg_rd_words == '0) && (cfg_wr_words == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if ((rd_issued == cfg_rd) && !bus.pu_rd_req && !rd_pend) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty && (wr_issued == cfg_wr) && !bus.pu_wr_req) state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(rd_pend && fifo_full));

endmodule
